round_sequencer: RTL
====================

// Module: round_sequencer
// PURPOSE
//  Control FSM for the baccarat table. Drives the card/wager load strobes, betting and result into
//  the datapath. Consumes pscore_out, dscore_out and pcard3_out, which the datapath returns.
//  One round per bet: BET -> deal P1,D1,P2,D2 -> third-card rules -> one-cycle result strobe -> DONE.
// PARAMETERS
//  DEAL_GAP   0  idle slow_clock cycles inserted after every load strobe (0..15)
//  STAND_MIN  6  player draws a third card iff pscore < STAND_MIN
// PORTS
//  slow_clock   in   1  sole clock; all state changes on its rising edge
//  resetb       in   1  synchronous reset, active-low
//  bet_confirm  in   1  level; sampled only in BET
//  new_round    in   1  level; sampled only in DONE
//  pscore       in   4  player hand total 0-9, valid 1 cycle after a player load
//  dscore       in   4  dealer hand total 0-9, valid 1 cycle after a dealer load
//  pcard3       in   4  player third card code (1-13; 0 = none)
//  betting      out  1  high in BET (datapath clears cards)
//  load_wager   out  1  one-cycle strobe latching bet/wager
//  load_pcard1/2/3, load_dcard1/2/3  out 1 each  one-cycle strobes, at most one high per cycle
//  result       out  2  00 none, 01 player, 10 dealer, 11 tie; nonzero for exactly one cycle
//  winner       out  2  same encoding; holds the round outcome through DONE, 00 elsewhere
//  round_done   out  1  high in DONE
// BEHAVIOUR
//  Reset (resetb=0 at edge): state=BET. All strobes=0, result=00, winner=00, gap counter=0.
//  betting=1 during reset and in BET. Reset mid-round aborts to BET with no result strobe.
//  BET: bet_confirm=1 -> load_wager=1 this cycle, next=DEAL_P1.
//  DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DEAL_P3, DEAL_D3: assert the matching load for one cycle.
//   The state then waits DEAL_GAP cycles (load low) before advancing.
//  Order P1 -> D1 -> P2 -> D2 -> EVAL1. EVAL1 lasts 1 cycle, so scores reflect the cards.
//  EVAL1, in priority order:
//   pscore>=8 or dscore>=8 (natural) -> RESULT
//   else pscore<STAND_MIN -> DEAL_P3
//   else dscore<=5 -> DEAL_D3
//   else -> RESULT
//  DEAL_P3 -> EVAL2. Third-card value v = (pcard3>=10) ? 0 : pcard3.
//  EVAL2, dealer draws iff:
//   dscore 0-2 always; 3 if v!=8; 4 if v in 2..7; 5 if v in 4..7; 6 if v in 6..7; 7 never.
//   Draw -> DEAL_D3, else RESULT.
//  DEAL_D3 -> RESULT.
//  RESULT (1 cycle): result = pscore>dscore ? 01 : dscore>pscore ? 10 : 11. winner loads same value.
//  DONE: result=00, winner held, round_done=1; new_round=1 -> BET (winner cleared).
//  Simultaneous events: bet_confirm outside BET and new_round outside DONE are ignored.
//   Both asserted in BET: only bet_confirm acts.
//  Out-of-range scores (>9) are treated as 9; no lockup. Unused state encodings go to BET.
// CONFIGURATION
//  WAGER_CHECK_EN defined: adds ports balance in 8, wager in 8, bet_reject out 1.
//   In BET, bet_confirm with wager==0 or wager>balance -> bet_reject=1 one cycle, no load_wager, stay BET.
//   balance==0 in BET -> state BROKE (betting=0, all strobes 0) until reset.
//  Not defined: ports absent; every bet_confirm is accepted.
// STRUCTURE
//  game_pkg: state enum; RES_NONE/RES_PLAYER/RES_DEALER/RES_TIE 2-bit constants; card_value() function.
//  Sub-module banker_rule: combinational (dscore, v) -> draw; instantiated once for EVAL2.
//  Top holds the state register, gap counter and winner register.
// TESTING
//  1 Reset, bet_confirm=1 -> load_wager 1 cycle, then load_pcard1, dcard1, pcard2, dcard2 on consecutive cycles (DEAL_GAP=0).
//  2 Natural: pscore=8, dscore=3 at EVAL1 -> no third loads; result=01 one cycle; winner=01 held; round_done=1.
//  3 pscore=4, dscore=5 -> load_pcard3; pcard3=12 (v=0) -> no dcard3; pscore=7, dscore=5 -> result=01.
//  4 pscore=2, dscore=3, pcard3=8 -> dealer stands; pcard3=9 -> load_dcard3; equal final scores -> result=11.
//  5 pscore=6, dscore=4 -> no pcard3, load_dcard3; DEAL_GAP=3 -> 3 idle cycles after each strobe.
//  6 resetb=0 during DEAL_P2 -> next cycle BET, betting=1, result=00; WAGER_CHECK_EN: wager=50, balance=20 -> bet_reject=1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the baccarat round sequencer.
package game_pkg;

  typedef enum logic [3:0] {
    StBet,
    StDealP1,
    StDealD1,
    StDealP2,
    StDealD2,
    StEval1,
    StDealP3,
    StEval2,
    StDealD3,
    StResult,
    StDone,
    StBroke
  } state_e;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_TIE    = 2'b11;

  // Baccarat value of a card code: tens and face cards count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= 4'd10) ? 4'd0 : code;
  endfunction

  // Hand totals above 9 are treated as 9 so a bad datapath value cannot wedge the FSM.
  function automatic logic [3:0] clamp_score(input logic [3:0] score);
    return (score > 4'd9) ? 4'd9 : score;
  endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card tableau: decides whether the dealer draws given the
// dealer total and the value of the player's third card.
module banker_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  output logic       draw
);

  // Tableau lookup on the (already clamped) dealer total.
  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for the baccarat table: bet, deal, third-card rules,
// result strobe and done. Optional wager checking is enabled by defining
// WAGER_CHECK_EN (adds balance/wager inputs and bet_reject output).
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned DEAL_GAP  = 0,
  parameter int unsigned STAND_MIN = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       bet_confirm,
  input  logic       new_round,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
`ifdef WAGER_CHECK_EN
  input  logic [7:0] balance,
  input  logic [7:0] wager,
  output logic       bet_reject,
`endif
  output logic       betting,
  output logic       load_wager,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic [1:0] result,
  output logic [1:0] winner,
  output logic       round_done
);

  localparam logic [3:0] GapInit = 4'(DEAL_GAP);

  state_e     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [1:0] winner_q, winner_d;

  logic [3:0] ps, ds;
  logic       dealer_draw;
  logic [1:0] outcome;

  assign ps = clamp_score(pscore);
  assign ds = clamp_score(dscore);
  assign outcome = (ps > ds) ? RES_PLAYER : (ds > ps) ? RES_DEALER : RES_TIE;

  banker_rule u_banker_rule (
    .dscore (ds),
    .v      (card_value(pcard3)),
    .draw   (dealer_draw)
  );

  // State, idle-gap counter and winner register; reset aborts any round.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q  <= StBet;
      gap_q    <= '0;
      winner_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      winner_q <= winner_d;
    end
  end

  // Next state and outputs. A nonzero gap count freezes the FSM with strobes low,
  // which realises the idle cycles after each load strobe.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    winner_d    = winner_q;
    betting     = (state_q == StBet);
    round_done  = (state_q == StDone);
    winner      = winner_q;
    load_wager  = 1'b0;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    result      = RES_NONE;
`ifdef WAGER_CHECK_EN
    bet_reject  = 1'b0;
`endif
    if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      case (state_q)
        StBet: begin
`ifdef WAGER_CHECK_EN
          if (balance == 8'd0) begin
            state_d = StBroke;
          end else if (bet_confirm) begin
            if ((wager == 8'd0) || (wager > balance)) begin
              bet_reject = 1'b1;
            end else begin
              load_wager = 1'b1;
              state_d    = StDealP1;
              gap_d      = GapInit;
            end
          end
`else
          if (bet_confirm) begin
            load_wager = 1'b1;
            state_d    = StDealP1;
            gap_d      = GapInit;
          end
`endif
        end
        StDealP1: begin
          load_pcard1 = 1'b1;
          state_d     = StDealD1;
          gap_d       = GapInit;
        end
        StDealD1: begin
          load_dcard1 = 1'b1;
          state_d     = StDealP2;
          gap_d       = GapInit;
        end
        StDealP2: begin
          load_pcard2 = 1'b1;
          state_d     = StDealD2;
          gap_d       = GapInit;
        end
        StDealD2: begin
          load_dcard2 = 1'b1;
          state_d     = StEval1;
          gap_d       = GapInit;
        end
        StEval1: begin
          if ((ps >= 4'd8) || (ds >= 4'd8)) state_d = StResult;
          else if (32'(ps) < STAND_MIN)     state_d = StDealP3;
          else if (ds <= 4'd5)              state_d = StDealD3;
          else                              state_d = StResult;
        end
        StDealP3: begin
          load_pcard3 = 1'b1;
          state_d     = StEval2;
          gap_d       = GapInit;
        end
        StEval2: begin
          state_d = dealer_draw ? StDealD3 : StResult;
        end
        StDealD3: begin
          load_dcard3 = 1'b1;
          state_d     = StResult;
          gap_d       = GapInit;
        end
        StResult: begin
          result   = outcome;
          winner_d = outcome;
          state_d  = StDone;
        end
        StDone: begin
          if (new_round) begin
            state_d  = StBet;
            winner_d = RES_NONE;
          end
        end
        StBroke: state_d = StBroke;
        default: begin
          state_d  = StBet;
          winner_d = RES_NONE;
        end
      endcase
    end
    // While reset is held the table looks like BET with everything quiet.
    if (!resetb) begin
      betting     = 1'b1;
      round_done  = 1'b0;
      winner      = RES_NONE;
      load_wager  = 1'b0;
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      result      = RES_NONE;
`ifdef WAGER_CHECK_EN
      bet_reject  = 1'b0;
`endif
    end
  end

endmodule
